// File: rtl/fifo_sync.sv
// fifo_sync -- single-clock FIFO with occupancy flags and overflow/underflow pulses.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   wr, datin     write request and data
//   rd            read request
//   datout, dato  read data and its valid flag
//   full, empy    occupancy == FIFO_LENGTH / occupancy == 0
//   almost_full   occupancy >= AF_LEVEL
//   almost_empty  occupancy <= AE_LEVEL
//   cont          current occupancy
//   ovf, udf      one-cycle pulse after a rejected write / read
//
// FWFT=0: datout is registered and updated by an accepted read, and dato pulses
// for the following cycle. FWFT=1: the head word is presented combinationally
// whenever the FIFO holds data.
module fifo_sync #(
    parameter int DATO_WIDTH  = 8,
    parameter int FIFO_LENGTH = 53,
    parameter int AF_LEVEL    = 48,
    parameter int AE_LEVEL    = 4,
    parameter int FWFT        = 0,
    localparam int CW         = $clog2(FIFO_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATO_WIDTH-1:0] datin,
    input  logic                  rd,
    output logic [DATO_WIDTH-1:0] datout,
    output logic                  dato,
    output logic                  full,
    output logic                  empy,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         cont,
    output logic                  ovf,
    output logic                  udf
);

    localparam int PW = $clog2(FIFO_LENGTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_LENGTH - 1);

    logic [DATO_WIDTH-1:0] mem [FIFO_LENGTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  wr_acc, rd_acc;

    // Flags are pure decodes of the registered count.
    assign full         = (cont == CW'(FIFO_LENGTH));
    assign empy         = (cont == '0);
    assign almost_full  = (int'(cont) >= AF_LEVEL);
    assign almost_empty = (int'(cont) <= AE_LEVEL);

    // Acceptance looks only at the current flags, so a simultaneous read never
    // makes room for a write into a full FIFO (and vice versa when empty).
    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empy;

    // Storage is never cleared; pointers and cont alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr] <= datin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cont   <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   cont <= cont + 1'b1;
                2'b01:   cont <= cont - 1'b1;
                default: cont <= cont;
            endcase
            ovf <= wr & full;
            udf <= rd & empy;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible while data is present; zero when empty so
            // reset leaves datout at 0.
            assign datout = empy ? '0 : mem[rd_ptr];
            assign dato   = ~empy;
        end else begin : g_std
            logic [DATO_WIDTH-1:0] dout_q;
            logic                  dato_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                    dato_q <= 1'b0;
                end else begin
                    dato_q <= rd_acc;
                    if (rd_acc)
                        dout_q <= mem[rd_ptr];
                end
            end
            assign datout = dout_q;
            assign dato   = dato_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync -- scoreboard bench for fifo_sync (standard and FWFT instances).
module tb_fifo_sync;

    localparam int LEN = 53;
    localparam int CW  = $clog2(LEN + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr, rd;
    logic [7:0]    datin, datout;
    logic          dato, full, empy, almost_full, almost_empty, ovf, udf;
    logic [CW-1:0] cont;

    logic          f_wr, f_rd;
    logic [7:0]    f_datin, f_datout;
    logic          f_dato, f_full, f_empy, f_af, f_ae, f_ovf, f_udf;
    logic [CW-1:0] f_cont;

    fifo_sync #(.DATO_WIDTH(8), .FIFO_LENGTH(LEN), .AF_LEVEL(48), .AE_LEVEL(4), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr(wr), .datin(datin), .rd(rd),
        .datout(datout), .dato(dato), .full(full), .empy(empy),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .cont(cont), .ovf(ovf), .udf(udf)
    );

    fifo_sync #(.DATO_WIDTH(8), .FIFO_LENGTH(LEN), .AF_LEVEL(48), .AE_LEVEL(4), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr(f_wr), .datin(f_datin), .rd(f_rd),
        .datout(f_datout), .dato(f_dato), .full(f_full), .empy(f_empy),
        .almost_full(f_af), .almost_empty(f_ae),
        .cont(f_cont), .ovf(f_ovf), .udf(f_udf)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq[$];     // model contents
    logic [7:0] exp_q[$];  // words expected on datout
    logic [7:0] last_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the standard instance: drive, advance the model, check all outputs.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        logic was_full, was_empty, wa, ra;
        int   sz;
        wr = w; datin = d; rd = r;
        was_full  = (mq.size() == LEN);
        was_empty = (mq.size() == 0);
        wa = w && !was_full;
        ra = r && !was_empty;
        if (ra) exp_q.push_back(mq.pop_front());
        if (wa) mq.push_back(d);
        @(posedge clk); #1;
        sz = mq.size();
        chk("ovf",   32'(ovf),          32'(w && was_full));
        chk("udf",   32'(udf),          32'(r && was_empty));
        chk("cont",  32'(cont),         32'(sz));
        chk("full",  32'(full),         32'(sz == LEN));
        chk("empy",  32'(empy),         32'(sz == 0));
        chk("afull", 32'(almost_full),  32'(sz >= 48));
        chk("aempt", 32'(almost_empty), 32'(sz <= 4));
        chk("dato",  32'(dato),         32'(ra));
        if (dato) begin
            if (exp_q.size() > 0) begin
                last_out = exp_q.pop_front();
                chk("datout", 32'(datout), 32'(last_out));
            end else begin
                chk("dato_spurious", 32'(dato), 32'(0));
            end
        end else begin
            chk("datout_hold", 32'(datout), 32'(last_out));
        end
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic do_reset(input logic w);
        rst = 1'b1; wr = w; datin = 8'h5A;
        @(posedge clk); #1;
        rst = 1'b0; wr = 1'b0;
        mq.delete(); exp_q.delete(); last_out = 8'h00;
        chk("rst_cont",  32'(cont),         32'(0));
        chk("rst_empy",  32'(empy),         32'(1));
        chk("rst_full",  32'(full),         32'(0));
        chk("rst_ae",    32'(almost_empty), 32'(1));
        chk("rst_af",    32'(almost_full),  32'(0));
        chk("rst_ovf",   32'(ovf),          32'(0));
        chk("rst_udf",   32'(udf),          32'(0));
        chk("rst_dato",  32'(dato),         32'(0));
        chk("rst_dout",  32'(datout),       32'(0));
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; datin = 8'h00;
        f_wr = 1'b0; f_rd = 1'b0; f_datin = 8'h00;
        last_out = 8'h00;
        @(posedge clk); #1;
        do_reset(1'b0);

        // Fill 0x01..0x35, then one rejected write; idle cycle confirms ovf is a single pulse.
        for (int i = 1; i <= LEN; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'hFF, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);

        // Drain, then one rejected read (datout must hold 0x35).
        for (int i = 0; i < LEN; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("drain_last", 32'(datout), 32'(8'h35));

        // Wrap: 50 in/out, then 10 words crossing index 52 -> 0.
        for (int i = 0; i < 50; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 50; i++) cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);

        // Simultaneous read/write at cont=5.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 1'b1);
        // Fill to full, then wr+rd: read accepted, write rejected.
        while (mq.size() < LEN) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        cyc(1'b1, 8'hEE, 1'b1);
        chk("simul_full_cont", 32'(cont), 32'(LEN - 1));
        while (mq.size() > 0) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // Reset mid-operation with wr held high.
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
        do_reset(1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_word", 32'(datout), 32'(8'h77));

        // FWFT instance (standard instance left idle).
        chk("fwft_idle_dato", 32'(f_dato), 32'(0));
        f_wr = 1'b1; f_datin = 8'h11;
        @(posedge clk); #1;
        f_wr = 1'b0;
        chk("fwft_dout1", 32'(f_datout), 32'(8'h11));
        chk("fwft_dato1", 32'(f_dato),   32'(1));
        f_wr = 1'b1; f_datin = 8'h22;
        @(posedge clk); #1;
        f_wr = 1'b0;
        chk("fwft_head",  32'(f_datout), 32'(8'h11));
        chk("fwft_cont2", 32'(f_cont),   32'(2));
        f_rd = 1'b1;
        @(posedge clk); #1;
        f_rd = 1'b0;
        chk("fwft_dout2", 32'(f_datout), 32'(8'h22));
        chk("fwft_dato2", 32'(f_dato),   32'(1));
        f_rd = 1'b1;
        @(posedge clk); #1;
        f_rd = 1'b0;
        chk("fwft_dato3", 32'(f_dato), 32'(0));
        chk("fwft_empy3", 32'(f_empy), 32'(1));
        chk("fwft_udf3",  32'(f_udf),  32'(0));
        f_rd = 1'b1;
        @(posedge clk); #1;
        f_rd = 1'b0;
        chk("fwft_udf4", 32'(f_udf), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
